// File: rtl/pc_fetch_unit.sv
// IF stage: architectural PC, instruction-memory address and the IF/ID register.
// Redirects from D follow delay-slot semantics; redirects seen during a stall are held until release.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int          IM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] flush_target,
  input  logic        redir_valid,
  input  logic [31:0] redir_target,
  output logic [31:0] im_addr,
  input  logic [31:0] im_rdata,
  output logic [31:0] f_pc,
  output logic        redir_pending,
  output logic [31:0] d_instr,
  output logic [31:0] d_pc,
  output logic        d_valid,
  output logic        d_exc
);

  // 33-bit bounds so IM_BASE + 4*IM_WORDS cannot wrap to a small value
  localparam logic [32:0] IM_LO = {1'b0, IM_BASE};
  localparam logic [32:0] IM_HI = {1'b0, IM_BASE} + 33'(4 * IM_WORDS);

  logic [31:0] f_pc_q, f_pc_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic        pend_q, pend_d;
  logic [31:0] d_instr_q, d_instr_d;
  logic [31:0] d_pc_q, d_pc_d;
  logic        d_valid_q, d_valid_d;
  logic        d_exc_q, d_exc_d;
  logic        fetch_bad;

  assign fetch_bad = (f_pc_q[1:0] != 2'b00) ||
                     ({1'b0, f_pc_q} < IM_LO) ||
                     ({1'b0, f_pc_q} >= IM_HI);

  always_comb begin
    f_pc_d     = f_pc_q;
    pend_tgt_d = pend_tgt_q;
    pend_d     = pend_q;
    d_instr_d  = d_instr_q;
    d_pc_d     = d_pc_q;
    d_valid_d  = d_valid_q;
    d_exc_d    = d_exc_q;
    if (flush) begin
      f_pc_d    = flush_target;
      d_instr_d = 32'h0;
      d_valid_d = 1'b0;
      d_exc_d   = 1'b0;
      pend_d    = 1'b0;
    end else if (stall) begin
      if (redir_valid) begin
        pend_d     = 1'b1;
        pend_tgt_d = redir_target;
      end
    end else begin
      if (redir_valid)  f_pc_d = redir_target;
      else if (pend_q)  f_pc_d = pend_tgt_q;
      else              f_pc_d = f_pc_q + 32'd4;
      pend_d    = 1'b0;
      // the instruction in F always advances: it is the delay slot of any redirect
      d_pc_d    = f_pc_q;
      d_valid_d = 1'b1;
      d_exc_d   = fetch_bad;
      d_instr_d = fetch_bad ? 32'h0 : im_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      f_pc_q     <= RESET_PC;
      pend_tgt_q <= 32'h0;
      pend_q     <= 1'b0;
      d_instr_q  <= 32'h0;
      d_pc_q     <= 32'h0;
      d_valid_q  <= 1'b0;
      d_exc_q    <= 1'b0;
    end else begin
      f_pc_q     <= f_pc_d;
      pend_tgt_q <= pend_tgt_d;
      pend_q     <= pend_d;
      d_instr_q  <= d_instr_d;
      d_pc_q     <= d_pc_d;
      d_valid_q  <= d_valid_d;
      d_exc_q    <= d_exc_d;
    end
  end

  assign im_addr       = f_pc_q;
  assign f_pc          = f_pc_q;
  assign redir_pending = pend_q;
  assign d_instr       = d_instr_q;
  assign d_pc          = d_pc_q;
  assign d_valid       = d_valid_q;
  assign d_exc         = d_exc_q;

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
IF-stage consumer of the next-PC value. Holds the architectural PC and drives the instruction-memory address. Applies branch/jump redirects from D with MIPS delay-slot semantics, plus stalls from the hazard unit and flushes from later stages. Registers the fetched instruction, PC and fetch-exception flag into the IF/ID pipeline register.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset
IM_BASE, 32'h0000_3000, lowest legal instruction address
IM_WORDS, 4096, instruction memory depth in words; legal range is [IM_BASE, IM_BASE+4*IM_WORDS)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-low reset
stall  in  1  hazard-unit stall; freezes PC and IF/ID
flush  in  1  later-stage redirect (exception/eret); highest priority
flush_target  in  32  PC to load on flush
redir_valid  in  1  D-stage branch taken or jump
redir_target  in  32  computed next PC from D
im_addr  out  32  instruction-memory address, combinational, equals f_pc
im_rdata  in  32  instruction word for im_addr, same cycle
f_pc  out  32  current fetch PC
redir_pending  out  1  a redirect was captured during stall and is not yet applied
d_instr  out  32  IF/ID instruction
d_pc  out  32  IF/ID PC
d_valid  out  1  IF/ID holds a real instruction
d_exc  out  1  IF/ID fetch address error (AdEL)

Behaviour:
- Reset (reset==0 at edge): f_pc=RESET_PC, d_instr=0, d_pc=0, d_valid=0, d_exc=0, pending=0. Reset overrides flush, stall and redirect.
- fetch_bad is combinational. It is 1 when f_pc[1:0]!=0, when f_pc<IM_BASE, or when f_pc>=IM_BASE+4*IM_WORDS. Compare unsigned in 33 bits so the upper bound does not wrap.
- Per-edge priority is flush > stall > normal.
- Flush:
  - f_pc<=flush_target; d_instr<=0, d_valid<=0, d_exc<=0, pending<=0.
  - Any redirect that edge is discarded.
- Stall (flush==0):
  - f_pc and all d_* hold.
  - If redir_valid, pending<=1 and pend_target<=redir_target; the latest redirect during a stall wins.
- Normal (flush==0, stall==0):
  - Next PC is chosen in this order:
    - redir_target if redir_valid;
    - else pend_target if pending;
    - else f_pc+4, with 32-bit wrap-around (32'hFFFF_FFFC+4=0).
  - pending<=0.
  - IF/ID loads:
    - d_pc<=f_pc, d_valid<=1, d_exc<=fetch_bad;
    - d_instr<=fetch_bad ? 0 : im_rdata.
- Delay slot: a redirect never squashes the instruction currently in F. That instruction always enters D, and the target is fetched one cycle after the redirect edge.
- Misaligned or out-of-range targets are still loaded into f_pc. The error is reported only via d_exc when that PC is fetched; the PC is not auto-corrected.
- Latency: redirect edge to target visible on im_addr is 1 cycle. When the redirect is captured during a stall, the target appears on im_addr the cycle after stall drops.
- redir_pending=pending (registered).
- A reset asserted mid-stall or with a redirect pending discards the pending redirect.

Test Plan:
- Reset then 4 free-running cycles:
  - f_pc sequence is 3000, 3004, 3008, 300C;
  - d_pc lags by one cycle;
  - d_valid=1 from the 2nd edge.
- At f_pc=3010, pulse redir_valid with target 3100:
  - d_pc=3010 and the instruction at 3010 enters D (delay slot);
  - the next f_pc is 3100.
- At f_pc=3020, stall 3 cycles with redir_valid target 3200 in stall cycle 1 and 3300 in cycle 2:
  - f_pc and d_* hold throughout;
  - redir_pending=1;
  - after release f_pc=3300 and pending=0.
- Simultaneous flush(target 4180), stall and redir_valid(3400):
  - f_pc=4180, d_valid=0, pending=0.
- Redirect to 3002, then to 2FFC:
  - each fetch gives d_exc=1, d_instr=0, d_pc equal to the bad address;
  - f_pc continues at 3006 and 3000 respectively.
- Assert reset while stalled with pending=1:
  - all outputs return to reset values, pending=0;
  - first fetch after reset release is 3000.
